// File: rtl/rv_pkg.sv
// Shared RV core types: widths and the fetch bundle
// carried from prefetch to decode.
package rv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam int INSTR_ALIGN = 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; storage cleared on reset
// so the head reads zero while empty out of reset.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/if_prefetch.sv
// Sequential instruction prefetcher: credit-limited
// requests, in-order response buffer, redirect flush.
module if_prefetch
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [ILEN-1:0] out_instr,
  input  logic            out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] target;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   occ;
  logic [CW+1:0]   credit_used;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;
  logic            req_fire;
  logic            rsp_drop;
  logic            rsp_take;
  logic            push;
  logic            pop;
  logic            empty;
  logic            full;

  assign credit_used = {2'b00, occ}
                     + {2'b00, inflight}
                     + {2'b00, discard};

  assign imem_req_valid = rst_n && !redirect_valid
                       && (credit_used < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (discard != '0);
  assign rsp_take = imem_rsp_valid && (discard == '0)
                 && (inflight != '0);

  assign push = rsp_take && !redirect_valid;
  assign pop  = out_valid && out_ready && !redirect_valid;

  assign target = {redirect_pc[XLEN-1:INSTR_ALIGN],
                   {INSTR_ALIGN{1'b0}}};

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign out_valid = !empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  // On redirect every outstanding word becomes a discard,
  // minus the one arriving in the redirect cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= target;
      rsp_pc   <= target;
      inflight <= '0;
      discard  <= inflight + discard
                - CW'(rsp_drop || rsp_take);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (rsp_take) rsp_pc <= rsp_pc + 32'd4;
      if (rsp_drop) discard <= discard - CW'(1);
      inflight <= inflight + CW'(req_fire)
                - CW'(rsp_take);
    end
  end

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (head),
    .count (occ),
    .empty (empty),
    .full  (full)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid && inflight == '0
                && discard == '0));
      assert (!(push && full));
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with a fixed-latency
// memory model returning addr ^ 0xA5A5_0000.
module tb_if_prefetch;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  logic [1:0]  lat_idx;
  logic [3:0]  mv;
  logic [31:0] ma [4];

  int checks;
  int errors;

  if_prefetch #(
    .RESET_PC (32'h0000_0100),
    .DEPTH    (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= '0;
      for (int i = 0; i < 4; i++) ma[i] <= '0;
    end else begin
      mv[0] <= imem_req_valid && imem_req_ready;
      ma[0] <= imem_req_addr;
      for (int i = 1; i < 4; i++) begin
        mv[i] <= mv[i-1];
        ma[i] <= ma[i-1];
      end
    end
  end

  assign imem_rsp_valid = mv[lat_idx];
  assign imem_rsp_data  = ma[lat_idx] ^ MASK;

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int l, input logic ordy);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    out_ready = ordy;
    lat_idx = 2'(l - 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    lat_idx = 2'd0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (out_pc !== 32'h0) begin
      errors++;
      $display("FAIL rst_out_pc got %h want 0", out_pc);
    end
    checks++;
    if (out_instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_out_instr got %h want 0", out_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL rst_first_req got %b/%h want 1/00000100",
               imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream;
    logic [31:0] e;
    do_reset(1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      e = 32'h100 + 32'(4 * k);
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin
        errors++;
        $display("FAIL stream_req c%0d got %b/%h want 1/%h",
                 k, imem_req_valid, imem_req_addr, e);
      end
      if (k >= 2) begin
        e = 32'h100 + 32'(4 * (k - 2));
        checks++;
        if (out_valid !== 1'b1 || out_pc !== e
            || out_instr !== (e ^ MASK)) begin
          errors++;
          $display("FAIL stream_out c%0d got %b/%h/%h want 1/%h/%h",
                   k, out_valid, out_pc, out_instr, e, e ^ MASK);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL stream_early c%0d got %b want 0",
                   k, out_valid);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure;
    int n;
    logic [31:0] e;
    n = 0;
    do_reset(1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      if (imem_req_valid && imem_req_ready) begin
        e = 32'h100 + 32'(4 * n);
        checks++;
        if (imem_req_addr !== e) begin
          errors++;
          $display("FAIL bp_req_addr got %h want %h",
                   imem_req_addr, e);
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL bp_req_count got %0d want 4", n);
    end
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < 6; j++) begin
      e = 32'h100 + 32'(4 * j);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== e
          || out_instr !== (e ^ MASK)) begin
        errors++;
        $display("FAIL bp_pop j%0d got %b/%h/%h want 1/%h/%h",
                 j, out_valid, out_pc, out_instr, e, e ^ MASK);
      end
      if (j == 0) begin
        checks++;
        if (imem_req_valid !== 1'b0) begin
          errors++;
          $display("FAIL bp_full_req got %b want 0", imem_req_valid);
        end
      end
      if (j == 1) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h110) begin
          errors++;
          $display("FAIL bp_resume got %b/%h want 1/00000110",
                   imem_req_valid, imem_req_addr);
        end
      end
      step();
    end
  endtask

  task automatic test_redirect;
    logic [31:0] e;
    do_reset(3, 1'b1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_gate got %b want 0", imem_req_valid);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL redir_req got %b/%h want 1/00000200",
               imem_req_valid, imem_req_addr);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_out_valid got %b want 0", out_valid);
    end
    e = 32'h200;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== e || out_instr !== (e ^ MASK)) begin
          errors++;
          $display("FAIL redir_seq got %h/%h want %h/%h",
                   out_pc, out_instr, e, e ^ MASK);
        end
        e = e + 32'd4;
      end
      step();
    end
    checks++;
    if (e < 32'h210) begin
      errors++;
      $display("FAIL redir_progress got next %h want >= 00000210", e);
    end
  endtask

  task automatic test_coincident;
    logic [31:0] e;
    do_reset(3, 1'b1);
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h104) begin
      errors++;
      $display("FAIL coin_pre got %b/%h want 1/00000104",
               out_valid, out_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL coin_gate got %b want 0", imem_req_valid);
    end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL coin_out_valid got %b want 0", out_valid);
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin
      errors++;
      $display("FAIL coin_req got %b/%h want 1/00000300",
               imem_req_valid, imem_req_addr);
    end
    e = 32'h300;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== e || out_instr !== (e ^ MASK)) begin
          errors++;
          $display("FAIL coin_seq got %h/%h want %h/%h",
                   out_pc, out_instr, e, e ^ MASK);
        end
        e = e + 32'd4;
      end
      step();
    end
    checks++;
    if (e < 32'h310) begin
      errors++;
      $display("FAIL coin_progress got next %h want >= 00000310", e);
    end
  endtask

  task automatic test_align_wrap;
    logic [31:0] e;
    int n;
    do_reset(1, 1'b1);
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h203;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++;
      $display("FAIL align_req got %b/%h want 1/00000200",
               imem_req_valid, imem_req_addr);
    end
    e = 32'h200;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== e) begin
          errors++;
          $display("FAIL align_seq got %h want %h", out_pc, e);
        end
        e = e + 32'd4;
      end
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    checks++;
    if (imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_req0 got %h want fffffffc", imem_req_addr);
    end
    step();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_req1 got %b/%h want 1/00000000",
               imem_req_valid, imem_req_addr);
    end
    e = 32'hFFFF_FFFC;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== e || out_instr !== (e ^ MASK)) begin
          errors++;
          $display("FAIL wrap_seq got %h/%h want %h/%h",
                   out_pc, out_instr, e, e ^ MASK);
        end
        e = e + 32'd4;
        n++;
      end
      step();
    end
    checks++;
    if (n < 3) begin
      errors++;
      $display("FAIL wrap_count got %0d want >= 3", n);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] e;
    int n;
    do_reset(1, 1'b0);
    step();
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      errors++;
      $display("FAIL mid_pre got %b/%h want 1/00000100",
               out_valid, out_pc);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got out %b req %b want 0/0",
               out_valid, imem_req_valid);
    end
    checks++;
    if (out_pc !== 32'h0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL mid_rst_head got %h/%h want 0/0",
               out_pc, out_instr);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      errors++;
      $display("FAIL mid_first_req got %b/%h want 1/00000100",
               imem_req_valid, imem_req_addr);
    end
    e = 32'h100;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      if (out_valid) begin
        checks++;
        if (out_pc !== e || out_instr !== (e ^ MASK)) begin
          errors++;
          $display("FAIL mid_seq got %h/%h want %h/%h",
                   out_pc, out_instr, e, e ^ MASK);
        end
        e = e + 32'd4;
        n++;
      end
      step();
    end
    checks++;
    if (n < 3) begin
      errors++;
      $display("FAIL mid_count got %0d want >= 3", n);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    out_ready = 1'b0;
    lat_idx = 2'd0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_coincident();
    test_align_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
Instruction prefetch unit sitting directly upstream of the core's fetch/decode path. It issues sequential word fetches to an external instruction memory over a valid/ready request channel and buffers in-order responses in a small FIFO. It presents {pc, instruction} pairs to the core with a valid/ready handshake. It takes redirects (taken branch/jump) from the core, flushing buffered and in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 4, FIFO entries and max (buffered + in-flight) words; power of 2, >= 2

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  async active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  32  word-aligned fetch address
imem_req_ready  in  1  memory accepts request
imem_rsp_valid  in  1  response valid; always accepted, in request order
imem_rsp_data  in  32  fetched instruction word
redirect_valid  in  1  core redirect (branch/jump taken)
redirect_pc  in  32  redirect target
out_valid  out  1  instruction available to core
out_pc  out  32  pc of head instruction
out_instr  out  32  head instruction
out_ready  in  1  core consumes head

Behaviour:
- Reset (async assert, sync deassert use): fetch_pc=RESET_PC, rsp_pc=RESET_PC, FIFO empty, inflight=0, discard=0. imem_req_valid=0 while rst_n low; out_valid=0, out_pc=0, out_instr=0 (FIFO storage cleared).
- Counters inflight/discard: $clog2(DEPTH)+1 bits. occupancy = FIFO count.
- Request: imem_req_valid = !redirect_valid && (occupancy + inflight + discard < DEPTH). imem_req_addr = fetch_pc. On req_valid&req_ready: fetch_pc += 4 (wraps 0xFFFF_FFFC -> 0), inflight++.
- Response: if discard>0, drop word, discard--. Else push {rsp_pc, rsp_data}, rsp_pc += 4, inflight--. Credit rule guarantees no overflow.
- Output: out_valid = !empty; out_pc/out_instr = head entry (combinational from storage). Pop on out_valid&out_ready.
- Redirect (redirect_valid=1), takes effect at the clock edge:
  - target = {redirect_pc[31:2], 2'b00}; fetch_pc <= target, rsp_pc <= target.
  - FIFO cleared. A pop in the same cycle is void; the core ignores that handshake.
  - No request issued this cycle.
  - discard <= discard + inflight - (rsp_valid ? 1 : 0). The response in the redirect cycle is itself dropped. inflight <= 0.
  - First post-redirect request is issued the next cycle at the earliest. out_valid is 0 the cycle after the redirect.
- Same-cycle request, response and pop without redirect: all apply; inflight net change = +req - rsp.
- rsp_valid with inflight=0 and discard=0 is a protocol error; the word is ignored. Flag with an assertion.
- instr 0x00000000 passes through unmodified; the core's exit detection is unchanged.
- Latency: with a 1-cycle memory, request at cycle N, response N+1, out_valid N+2. Steady state is 1 instr/cycle when DEPTH >= 3.
- Reset mid-operation: immediate return to reset state; responses still pending from memory after rst_n rises are not tracked. The memory is reset on the same rst_n.

Decomposition:
- Shared package rv_pkg: XLEN=32, ILEN=32, INSTR_ALIGN=2, typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr;}.
- One sub-module: sync_fifo (parameter WIDTH, DEPTH; push/pop/flush/count/empty/full), instantiated with WIDTH=64.
- Counter/credit/redirect logic stays in if_prefetch.

Test Plan:
- Stream: RESET_PC=0x100, req_ready=1, 1-cycle memory returning addr^0xA5A5_0000, out_ready=1 -> req addrs 0x100,0x104,0x108...; first out_valid 2 cycles after first request with out_pc=0x100, out_instr=0xA5A5_0100; then 1 instr/cycle.
- Backpressure: out_ready=0 -> exactly 4 requests accepted, then req_valid=0, FIFO holds 0x100..0x10C. Raise out_ready -> pops in order, requests resume at 0x110.
- Redirect with 2 in flight (3-cycle memory), redirect_pc=0x200 -> next 2 responses dropped. Next request addr 0x200; first out_pc=0x200; no 0x10x pcs appear after the redirect.
- Redirect coincident with response, pop and req_ready=1 -> no request that cycle, response dropped, out_valid=0 next cycle, discard = prior inflight-1.
- Alignment/wrap: redirect_pc=0x203 -> req addr 0x200. Redirect to 0xFFFF_FFFC -> next request addr 0x0000_0000, out_pc sequence FFFF_FFFC, 0000_0000.
- Reset mid-stream with FIFO half full -> out_valid=0, req_valid=0 immediately. After release, first req addr = RESET_PC.
